// File: rtl/dly_ctrl_pkg.sv
// Shared types and constants for the delay-line select controller.
package dly_ctrl_pkg;

  localparam int SEL_W = 2;
  localparam logic [SEL_W-1:0] SEL_LONGEST  = 2'b11;
  localparam logic [SEL_W-1:0] SEL_SHORTEST = 2'b00;

  // A fresh request ignores the first samples, which may predate the request.
  localparam logic [7:0] SYNC_STAGES = 8'd2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_QUIET,
    APPLY,
    DONE,
    ERR,
    SWEEP
  } state_t;

endpackage

// File: rtl/dly_sync2.sv
// Two-flop synchroniser for asynchronous delay-line taps, one chain per bit.
module dly_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_d, meta_q;
  logic [W-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/delay_select_ctrl.sv
// Applies delay_select updates to matched-delay lines only while the target line is quiet.
// Optional macro DLY_SWEEP_EN adds a sweep that walks every line from 11 down to 00.
module delay_select_ctrl
  import dly_ctrl_pkg::*;
#(
  parameter int              NUM_LINES  = 5,
  parameter int              SETTLE_CYC = 4,
  parameter int              TIMEOUT    = 255,
  parameter logic [SEL_W-1:0] RST_SEL   = SEL_LONGEST
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [2:0]             cfg_line,
  input  logic [SEL_W-1:0]       cfg_sel,
  input  logic [NUM_LINES-1:0]   line_in,
  input  logic [NUM_LINES-1:0]   line_out,
`ifdef DLY_SWEEP_EN
  input  logic                   sweep_start,
  output logic                   sweep_busy,
`endif
  output logic [2*NUM_LINES-1:0] dly_sel,
  output logic                   done_pulse,
  output logic                   err_pulse
);

  localparam logic [3:0] SETTLE_LIM = 4'(SETTLE_CYC);
  localparam logic [7:0] TMO_LIM    = 8'(TIMEOUT);

  logic [NUM_LINES-1:0] sync_in, sync_out, quiet;

  dly_sync2 #(.W(NUM_LINES)) u_sync_in (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (line_in),
    .q     (sync_in)
  );

  dly_sync2 #(.W(NUM_LINES)) u_sync_out (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (line_out),
    .q     (sync_out)
  );

  assign quiet = ~(sync_in ^ sync_out);

  state_t                 state_d, state_q;
  logic [2:0]             line_d, line_q;
  logic [SEL_W-1:0]       sel_d, sel_q;
  logic [3:0]             quiet_cnt_d, quiet_cnt_q;
  logic [7:0]             tmo_cnt_d, tmo_cnt_q;
  logic [2*NUM_LINES-1:0] dly_sel_d, dly_sel_q;
  logic                   cfg_ready_d, cfg_ready_q;
  logic                   done_d, done_q;
  logic                   err_d, err_q;
  logic                   quiet_sel;
  logic [SEL_W-1:0]       cur_sel_cfg;
`ifdef DLY_SWEEP_EN
  logic                   sweep_d, sweep_q;
  logic [SEL_W-1:0]       cur_sel_line;
`endif

  function automatic logic [SEL_W-1:0] sel_of(input logic [2*NUM_LINES-1:0] bus,
                                               input logic [2:0] idx);
    sel_of = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (idx == 3'(i)) sel_of = bus[SEL_W*i +: SEL_W];
    end
  endfunction

  always_comb begin
    quiet_sel = 1'b0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (line_q == 3'(i)) quiet_sel = quiet[i];
    end
  end

  assign cur_sel_cfg = sel_of(dly_sel_q, cfg_line);
`ifdef DLY_SWEEP_EN
  assign cur_sel_line = sel_of(dly_sel_q, line_q);
`endif

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    sel_d       = sel_q;
    quiet_cnt_d = quiet_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    dly_sel_d   = dly_sel_q;
`ifdef DLY_SWEEP_EN
    sweep_d     = sweep_q;
`endif
    case (state_q)
      IDLE: begin
        if (cfg_valid && cfg_ready_q) begin
          line_d      = cfg_line;
          sel_d       = cfg_sel;
          quiet_cnt_d = '0;
          tmo_cnt_d   = '0;
          if (int'(cfg_line) >= NUM_LINES) state_d = ERR;
          else if (cfg_sel == cur_sel_cfg) state_d = DONE;
          else                             state_d = WAIT_QUIET;
        end
`ifdef DLY_SWEEP_EN
        else if (sweep_start) begin
          sweep_d = 1'b1;
          line_d  = '0;
          state_d = SWEEP;
        end
`endif
      end
      WAIT_QUIET: begin
        if (tmo_cnt_q != 8'hFF) tmo_cnt_d = tmo_cnt_q + 8'd1;
        if (tmo_cnt_q < SYNC_STAGES || !quiet_sel) quiet_cnt_d = '0;
        else if (quiet_cnt_q != 4'hF)              quiet_cnt_d = quiet_cnt_q + 4'd1;
        // Settling takes priority over a timeout landing on the same cycle.
        if (quiet_cnt_d >= SETTLE_LIM)  state_d = APPLY;
        else if (tmo_cnt_d >= TMO_LIM)  state_d = ERR;
      end
      APPLY: begin
        for (int i = 0; i < NUM_LINES; i++) begin
          if (line_q == 3'(i)) dly_sel_d[SEL_W*i +: SEL_W] = sel_q;
        end
        state_d = DONE;
`ifdef DLY_SWEEP_EN
        if (sweep_q) state_d = SWEEP;
`endif
      end
      DONE: state_d = IDLE;
      ERR: begin
        state_d = IDLE;
`ifdef DLY_SWEEP_EN
        sweep_d = 1'b0;
`endif
      end
`ifdef DLY_SWEEP_EN
      SWEEP: begin
        if (cur_sel_line != SEL_SHORTEST) begin
          sel_d       = cur_sel_line - 2'd1;
          quiet_cnt_d = '0;
          tmo_cnt_d   = '0;
          state_d     = WAIT_QUIET;
        end else if (int'(line_q) >= NUM_LINES - 1) begin
          sweep_d = 1'b0;
          state_d = DONE;
        end else begin
          line_d = line_q + 3'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    cfg_ready_d = (state_d == IDLE);
    done_d      = (state_q == DONE);
    err_d       = (state_q == ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      line_q      <= '0;
      sel_q       <= '0;
      quiet_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      dly_sel_q   <= {NUM_LINES{RST_SEL}};
      cfg_ready_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef DLY_SWEEP_EN
      sweep_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      sel_q       <= sel_d;
      quiet_cnt_q <= quiet_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      dly_sel_q   <= dly_sel_d;
      cfg_ready_q <= cfg_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef DLY_SWEEP_EN
      sweep_q     <= sweep_d;
`endif
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign dly_sel    = dly_sel_q;
  assign done_pulse = done_q;
  assign err_pulse  = err_q;
`ifdef DLY_SWEEP_EN
  assign sweep_busy = sweep_q;
`endif

endmodule
